timer_slave: RTL

- Memory-mapped 32-bit timer/compare peripheral on the data-memory side of the CPU bus.
- Responds to the same ce/we/sel/addr/data single-cycle protocol the CPU uses toward data RAM.
- The SOPC address decoder drives ce for the timer's address window.
- Provides a programmable prescaler, a free-running or auto-reload counter, a compare-match flag and a level interrupt to the CPU.

---
 rtl/timer_slave_pkg.sv | 21 ++
 rtl/timer_slave_if.sv | 14 +
 rtl/timer_prescaler.sv | 29 ++
 rtl/timer_slave.sv | 125 ++++++++++++
 4 files changed

// File: rtl/timer_slave_pkg.sv
// Shared definitions for the timer peripheral: register offsets and field positions.
package timer_slave_pkg;

    // Register index taken from addr[3:2].
    typedef enum logic [1:0] {
        TIMER_CTRL    = 2'd0,
        TIMER_COUNT   = 2'd1,
        TIMER_COMPARE = 2'd2,
        TIMER_STATUS  = 2'd3
    } reg_sel_e;

    // CTRL bit positions.
    localparam int CTRL_EN           = 0;
    localparam int CTRL_AUTO_RELOAD  = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int CTRL_PRESCALE_LSB = 8;

    // STATUS bit positions.
    localparam int STATUS_MATCH = 0;

endpackage

// File: rtl/timer_slave_if.sv
// Single-cycle data-memory style bus (ce/we/sel/addr/data) seen by the timer.
interface timer_slave_if #(
    parameter int DATA_W = 32
);
    logic              ce;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [3:0]        sel;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;

    modport master (output ce, we, addr, sel, data_i, input data_o);
    modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/timer_prescaler.sv
// Programmable prescaler: counts 0..prescale and pulses tick on the terminal count.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;

    assign tick = en && (cnt_q == prescale);

    // Prescale counter: held at zero while disabled or cleared, wraps after the tick.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr || !en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/timer_slave.sv
// Memory-mapped timer/compare peripheral: CTRL, COUNT, COMPARE and W1C STATUS registers.
module timer_slave
    import timer_slave_pkg::*;
#(
    parameter int               DATA_W        = 32,
    parameter int               PRESCALE_W    = 8,
    parameter logic [DATA_W-1:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic           clk,
    input  logic           rst,
    timer_slave_if.slave   bus,
    output logic           irq_o
);

    // Writable CTRL bits: EN, AUTO_RELOAD, IRQ_EN and the PRESCALE field.
    localparam logic [DATA_W-1:0] CTRL_MASK =
        ((DATA_W'(1) << (CTRL_PRESCALE_LSB + PRESCALE_W)) - (DATA_W'(1) << CTRL_PRESCALE_LSB))
        | DATA_W'(7);

    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] compare_q;
    logic              match_q;

    logic [DATA_W-1:0] ctrl_d;
    logic [DATA_W-1:0] count_d;
    logic [DATA_W-1:0] compare_d;
    logic              match_d;
    logic [DATA_W-1:0] rdata;

    logic     tick;
    logic     hit;
    logic     wr_any;
    logic     wr_ctrl;
    logic     wr_count;
    logic     wr_compare;
    logic     wr_status;
    reg_sel_e reg_idx;
    logic     unused_addr;

    // Replace only the byte lanes enabled by sel.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [3:0]        lanes
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign reg_idx     = reg_sel_e'(bus.addr[3:2]);
    assign unused_addr = ^{bus.addr[DATA_W-1:4], bus.addr[1:0]};

    // A write with no lanes enabled touches nothing, including the prescaler.
    assign wr_any     = bus.ce && bus.we && (bus.sel != 4'b0000);
    assign wr_ctrl    = wr_any && (reg_idx == TIMER_CTRL);
    assign wr_count   = wr_any && (reg_idx == TIMER_COUNT);
    assign wr_compare = wr_any && (reg_idx == TIMER_COMPARE);
    assign wr_status  = wr_any && (reg_idx == TIMER_STATUS);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CTRL_EN]),
        .clr      (wr_ctrl),
        .prescale (ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_W]),
        .tick     (tick)
    );

    // Next-state: tick update first, CPU lane writes layered on top; compare uses pre-edge values.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        hit       = tick && (count_q == compare_q);

        if (tick) begin
            count_d = (hit && ctrl_q[CTRL_AUTO_RELOAD]) ? '0 : count_q + DATA_W'(1);
        end
        if (wr_count)   count_d   = lane_merge(count_d, bus.data_i, bus.sel);
        if (wr_compare) compare_d = lane_merge(compare_q, bus.data_i, bus.sel);
        if (wr_ctrl)    ctrl_d    = lane_merge(ctrl_q, bus.data_i, bus.sel) & CTRL_MASK;

        // A new match outranks a simultaneous write-1-to-clear.
        match_d = hit || (match_q && !(wr_status && bus.sel[0] && bus.data_i[STATUS_MATCH]));
    end

    // Register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= RESET_COMPARE;
            match_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    // Read mux; sel plays no part in reads.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            TIMER_CTRL:    rdata = ctrl_q;
            TIMER_COUNT:   rdata = count_q;
            TIMER_COMPARE: rdata = compare_q;
            TIMER_STATUS:  rdata = DATA_W'(match_q) << STATUS_MATCH;
            default:       rdata = '0;
        endcase
    end

    assign bus.data_o = (rst && bus.ce && !bus.we) ? rdata : '0;
    assign irq_o      = match_q && ctrl_q[CTRL_IRQ_EN];

endmodule
